bnn_conv_stream: RTL and testbench
==================================

# bnn_conv_stream

Parametrised binary-weight streaming convolution engine for the BNN datapath. It is the successor to `conv_mix`, generalised in image width, kernel size, data width and output-channel count, with ready/valid backpressure on both sides. Pixels stream in raster order, a line buffer forms K×K windows, and each window is multiplied by OUT_CH banks of ±1 weights and accumulated. The block sits between the image/feature-map source and the pooling/threshold stage.

## Interface
- DATA_W, 32: signed pixel width.
- IMG_W, 28: square input image side, ≥ K.
- K, 5: square kernel side, ≥ 2.
- OUT_CH, 1: output channels computed in parallel.
- ACC_W, DATA_W + $clog2(K*K) + 1: signed accumulator width per channel.
- clk  in  1  rising-edge clock.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a frame when IDLE.
- weight_en  in  1  serial weight load enable; honoured only in IDLE.
- weight  in  1  weight bit; 1 = +1, 0 = −1.
- din_valid  in  1  pixel valid.
- din  in  DATA_W  signed pixel.
- din_ready  out  1  pixel accepted when din_valid && din_ready.
- dout_valid  out  1  output word valid.
- dout_ready  in  1  consumer ready.
- dout  out  OUT_CH*ACC_W  signed sums; channel c at bits [c*ACC_W +: ACC_W].
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse after the last output handshake.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE: when weight_en=1, weight shifts into a OUT_CH*K*K bit register (new bit enters LSB). The first bit shifted in ends up as channel OUT_CH−1, tap (K−1,K−1). Taps within a channel are row-major; tap (0,0) is the top-left window pixel. start=1 → RUN, with row/col counters cleared.
- RUN: din_ready = !dout_valid || dout_ready.
  - Each accepted pixel advances col; at IMG_W−1, col wraps to 0 and row increments.
  - The pixel enters the line buffer (K−1 rows of IMG_W) and the K×K window shift registers.
  - A window completes when the accepted pixel has row ≥ K−1 and col ≥ K−1. Then dout is loaded next edge and dout_valid is set.
  - Per channel: sum over taps of (w ? +p : −p), computed at full ACC_W with sign extension and no saturation.
- Accepting pixel IMG_W*IMG_W−1 → DRAIN. din_ready=0 in DRAIN.
- DRAIN: when dout_valid is clear or handshakes → DONE.
- DONE: done=1 for one cycle → IDLE. Weights are retained for the next frame.
- Outputs per frame: (IMG_W−K+1)², for example 576 for 28/5.
- start while busy: ignored. weight_en outside IDLE: ignored. start and weight_en together in IDLE: the weight shifts and the FSM enters RUN.
- dout holds stable while dout_valid && !dout_ready.
- Reset, including mid-frame: all state cleared, weights cleared to all 0 (−1), FSM → IDLE. The partial frame is discarded.

## Timing
- Reset values: din_ready=0, dout_valid=0, dout=0, busy=0, done=0.
- din_ready rises the cycle after start is sampled in IDLE.
- Latency: the pixel completing a window is accepted at edge t, and dout_valid=1 from edge t onward (registered at t, visible in cycle t+1).
- Throughput: 1 pixel/cycle with dout_ready held at 1.
- Backpressure: if dout_valid=1 and dout_ready=0, din_ready=0 in the same cycle. No pixel is lost and no output is overwritten.
- dout_valid falls the edge after the handshake, unless a new window completes on that same edge; in that case it stays 1 with new data.
- done asserts exactly one cycle after DRAIN exits. Minimum frame: IMG_W² + 2 cycles from start.

## Structure
- Package bnn_pkg holds:
  - the FSM state enum
  - the ACC_W helper function
  - the weight polarity constants W_POS=1, W_NEG=0
- Sub-module bnn_line_buffer (DATA_W, IMG_W, K) provides the K−1 row delay lines and the K×K window taps, advanced by a shift enable.
- The top level holds the FSM, counters, weight register, multiply-accumulate adder tree and the output register.

## Test plan
- K=3, IMG_W=4, OUT_CH=1; load 9 ones; stream 16 pixels of value 1; dout_ready=1 → 4 outputs of 9, then a done pulse. The first dout_valid appears the cycle after pixel index 10 is accepted.
- Same configuration with 9 zeros loaded and pixels of value 2 → 4 outputs of −18.
- OUT_CH=2, K=3; ch0 all +1, ch1 alternating +/− starting at tap (0,0)=+1; pixels 0..15 → ch0 window sums 45,54,81,90; ch1 sums match the software model.
- Backpressure: dout_ready toggling 1,0,0,1,…; din_valid with random gaps → the output sequence is identical to the free-running case, and din_ready=0 on every stalled cycle.
- Default parameters with a 784-pixel image → exactly 576 outputs matching the golden file; busy falls together with the done pulse.
- Reset asserted after pixel 100; then reload weights, start, and run a full frame → no stale output appears, and the results match a clean run.

Source files
------------

// File: rtl/bnn_pkg.sv
// Shared types and helpers for the binary-weight convolution datapath.
package bnn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } bnn_state_e;

  localparam logic W_POS = 1'b1;
  localparam logic W_NEG = 1'b0;

  // One guard bit on top of the K*K growth so -(min pixel) never overflows.
  function automatic int acc_w(input int data_w, input int k);
    return data_w + $clog2(k * k) + 1;
  endfunction

endpackage

// File: rtl/bnn_conv_stream_if.sv
// Pixel-in / window-sum-out valid-ready bundle; slave is the engine, master the environment.
interface bnn_conv_stream_if
  import bnn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int K      = 5,
  parameter int OUT_CH = 1,
  parameter int ACC_W  = acc_w(DATA_W, K)
);

  logic                      din_valid;
  logic                      din_ready;
  logic [DATA_W-1:0]         din;
  logic                      dout_valid;
  logic                      dout_ready;
  logic [OUT_CH*ACC_W-1:0]   dout;

  modport slave (
    input  din_valid, din, dout_ready,
    output din_ready, dout_valid, dout
  );

  modport master (
    output din_valid, din, dout_ready,
    input  din_ready, dout_valid, dout
  );

endinterface

// File: rtl/bnn_line_buffer.sv
// K-1 row delay lines plus a K x K window; taps_o shows the window including pix_i,
// i.e. the window that becomes current once shift_en_i is taken.
module bnn_line_buffer #(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 28,
  parameter int K      = 5
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      shift_en_i,
  input  logic [DATA_W-1:0]         pix_i,
  output logic [K*K*DATA_W-1:0]     taps_o
);

  localparam int SR_LEN = (K - 1) * IMG_W;

  logic [DATA_W-1:0] sr_q  [SR_LEN];
  logic [DATA_W-1:0] win_q [K][K-1];
  logic [DATA_W-1:0] row_in [K];

  // sr_q[i] holds the pixel accepted i+1 shifts ago, so row r lags by (K-1-r) lines.
  for (genvar r = 0; r < K - 1; r++) begin : g_row_in
    assign row_in[r] = sr_q[(K - 1 - r) * IMG_W - 1];
  end
  assign row_in[K-1] = pix_i;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < SR_LEN; i++) sr_q[i] <= '0;
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 1; c++) win_q[r][c] <= '0;
      end
    end else if (shift_en_i) begin
      sr_q[0] <= pix_i;
      for (int i = 1; i < SR_LEN; i++) sr_q[i] <= sr_q[i-1];
      for (int r = 0; r < K; r++) begin
        for (int c = 0; c < K - 2; c++) win_q[r][c] <= win_q[r][c+1];
        win_q[r][K-2] <= row_in[r];
      end
    end
  end

  for (genvar r = 0; r < K; r++) begin : g_tap_r
    for (genvar c = 0; c < K; c++) begin : g_tap_c
      if (c < K - 1) begin : g_reg
        assign taps_o[(r*K + c)*DATA_W +: DATA_W] = win_q[r][c];
      end else begin : g_new
        assign taps_o[(r*K + c)*DATA_W +: DATA_W] = row_in[r];
      end
    end
  end

endmodule

// File: rtl/bnn_conv_stream.sv
// Streaming K x K binary-weight convolution: window sum registered on the edge that accepts
// its last pixel; input stalls whenever a pending output is not taken.
module bnn_conv_stream
  import bnn_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 28,
  parameter int K      = 5,
  parameter int OUT_CH = 1,
  parameter int ACC_W  = acc_w(DATA_W, K)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic               weight_en,
  input  logic               weight,
  bnn_conv_stream_if.slave   io,
  output logic               busy,
  output logic               done
);

  localparam int NTAP = K * K;
  localparam int NW   = OUT_CH * NTAP;
  localparam int CW   = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam logic [CW-1:0] LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] KM1  = CW'(K - 1);

  bnn_state_e               state_q, state_d;
  logic [CW-1:0]            row_q, row_d;
  logic [CW-1:0]            col_q, col_d;
  logic [NW-1:0]            w_q, w_d;
  logic                     vld_q, vld_d;
  logic [OUT_CH*ACC_W-1:0]  dout_q, dout_d;

  logic                     din_rdy;
  logic                     accept;
  logic [NTAP*DATA_W-1:0]   taps;
  logic [OUT_CH*ACC_W-1:0]  sums;

  bnn_line_buffer #(
    .DATA_W (DATA_W),
    .IMG_W  (IMG_W),
    .K      (K)
  ) u_lb (
    .clk        (clk),
    .rstn       (rstn),
    .shift_en_i (accept),
    .pix_i      (io.din),
    .taps_o     (taps)
  );

  // Weight bit c*NTAP + t selects the sign of tap t (row-major) in channel c.
  for (genvar c = 0; c < OUT_CH; c++) begin : g_ch
    logic signed [ACC_W-1:0] acc;
    always_comb begin
      acc = '0;
      for (int t = 0; t < NTAP; t++) begin
        if (w_q[c*NTAP + t] == W_POS) acc = acc + ACC_W'($signed(taps[t*DATA_W +: DATA_W]));
        else                          acc = acc - ACC_W'($signed(taps[t*DATA_W +: DATA_W]));
      end
    end
    assign sums[c*ACC_W +: ACC_W] = acc;
  end

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    w_d     = w_q;
    vld_d   = vld_q;
    dout_d  = dout_q;
    din_rdy = 1'b0;
    accept  = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (weight_en) w_d = {w_q[NW-2:0], weight};
        if (start) begin
          state_d = ST_RUN;
          row_d   = '0;
          col_d   = '0;
        end
      end
      ST_RUN: begin
        busy    = 1'b1;
        din_rdy = !vld_q || io.dout_ready;
        if (vld_q && io.dout_ready) vld_d = 1'b0;
        if (io.din_valid && din_rdy) begin
          accept = 1'b1;
          // A fresh window overrides the clear from a same-edge handshake.
          if (row_q >= KM1 && col_q >= KM1) begin
            vld_d  = 1'b1;
            dout_d = sums;
          end
          if (col_q == LAST) begin
            col_d = '0;
            row_d = (row_q == LAST) ? '0 : row_q + 1'b1;
            if (row_q == LAST) state_d = ST_DRAIN;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        busy = 1'b1;
        if (!vld_q || io.dout_ready) begin
          vld_d   = 1'b0;
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done    = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
      row_q   <= '0;
      col_q   <= '0;
      w_q     <= {NW{W_NEG}};
      vld_q   <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
      col_q   <= col_d;
      w_q     <= w_d;
      vld_q   <= vld_d;
      dout_q  <= dout_d;
    end
  end

  assign io.din_ready  = din_rdy;
  assign io.dout_valid = vld_q;
  assign io.dout       = dout_q;

endmodule

// File: tb/tb_bnn_conv_stream.sv
// Directed frames on a 4x4 image, 3x3 kernel, two channels, with hand-computed window sums.
module tb_bnn_conv_stream;
  import bnn_pkg::*;

  localparam int DW = 16;
  localparam int IW = 4;
  localparam int KK = 3;
  localparam int OC = 2;
  localparam int AW = acc_w(DW, KK);
  localparam int NPIX = IW * IW;
  localparam int NOUT = (IW - KK + 1) * (IW - KK + 1);

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic start = 1'b0;
  logic weight_en = 1'b0;
  logic weight = 1'b0;
  logic busy, done;

  bnn_conv_stream_if #(.DATA_W(DW), .K(KK), .OUT_CH(OC)) io ();

  bnn_conv_stream #(
    .DATA_W (DW),
    .IMG_W  (IW),
    .K      (KK),
    .OUT_CH (OC)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .weight_en (weight_en),
    .weight    (weight),
    .io        (io),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  longint        exp0 [NOUT];
  longint        exp1 [NOUT];
  logic [DW-1:0] pix  [NPIX];

  task automatic check_val(input string tag, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic load_weights(input logic [17:0] bits, input bit with_start);
    for (int i = 17; i >= 0; i--) begin
      @(negedge clk);
      weight_en = 1'b1;
      weight    = bits[i];
      start     = with_start && (i == 0);
    end
    @(negedge clk);
    weight_en = 1'b0;
    start     = 1'b0;
  endtask

  // Entered at a negedge; leaves at a negedge with the engine back in IDLE.
  task automatic run_frame(input bit do_start, input bit gaps, input bit bp, input bit junk_we);
    int idx = 0;
    int nout = 0;
    int cyc = 0;
    bit done_seen = 0;
    bit arm = 0;
    bit prev_stall = 0;
    logic [OC*AW-1:0] prev_dout = '0;
    if (do_start) begin
      @(negedge clk);
      check_val("ready_idle", io.din_ready, 0);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
    end
    #1;
    check_val("ready_after_start", io.din_ready, 1);
    check_val("busy_run", busy, 1);
    weight_en = junk_we;
    weight    = 1'b0;
    while (cyc < 300) begin
      if (arm) begin
        check_val("first_valid_latency", io.dout_valid, 1);
        arm = 0;
      end
      if (done) begin
        done_seen = 1;
        weight_en = 1'b0;
        check_val("busy_at_done", busy, 0);
        check_val("out_count", nout, NOUT);
        if (!gaps && !bp) check_val("frame_cycles", cyc, NPIX + 1);
        break;
      end
      io.din_valid  = (idx < NPIX) && (!gaps || $urandom_range(0, 2) != 0);
      io.din        = (idx < NPIX) ? pix[idx] : '0;
      io.dout_ready = bp ? ((cyc % 4 == 0) || (cyc % 4 == 3)) : 1'b1;
      #1;
      if (prev_stall) check_val("dout_hold", (io.dout == prev_dout), 1);
      if (io.dout_valid && !io.dout_ready) check_val("stall_din_ready", io.din_ready, 0);
      if (io.dout_valid && io.dout_ready) begin
        if (nout < NOUT) begin
          check_val("ch0_sum", $signed(io.dout[0 +: AW]), exp0[nout]);
          check_val("ch1_sum", $signed(io.dout[AW +: AW]), exp1[nout]);
        end else begin
          check_val("extra_output", nout, NOUT - 1);
        end
        nout++;
      end
      if (io.din_valid && io.din_ready) begin
        if (idx == (KK - 1) * IW + (KK - 1)) begin
          check_val("no_early_valid", io.dout_valid, 0);
          arm = 1;
        end
        idx++;
      end
      prev_stall = io.dout_valid && !io.dout_ready;
      prev_dout  = io.dout;
      @(negedge clk);
      cyc++;
    end
    check_val("done_seen", done_seen, 1);
    io.din_valid = 1'b0;
    @(negedge clk);
    check_val("done_pulse_width", done, 0);
  endtask

  task automatic set_exp(input longint a0, input longint a1, input longint a2, input longint a3,
                         input longint b0, input longint b1, input longint b2, input longint b3);
    exp0[0] = a0; exp0[1] = a1; exp0[2] = a2; exp0[3] = a3;
    exp1[0] = b0; exp1[1] = b1; exp1[2] = b2; exp1[3] = b3;
  endtask

  initial begin
    io.din_valid  = 1'b0;
    io.din        = '0;
    io.dout_ready = 1'b0;
    #1;
    check_val("rst_din_ready", io.din_ready, 0);
    check_val("rst_dout_valid", io.dout_valid, 0);
    check_val("rst_dout", io.dout, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_done", done, 0);
    repeat (2) @(negedge clk);
    rstn = 1'b1;

    // All +1 weights, unit pixels.
    load_weights(18'h3FFFF, 0);
    for (int i = 0; i < NPIX; i++) pix[i] = 16'd1;
    set_exp(9, 9, 9, 9, 9, 9, 9, 9);
    run_frame(1, 0, 0, 0);

    // All -1 weights, pixels of 2.
    load_weights(18'h00000, 0);
    for (int i = 0; i < NPIX; i++) pix[i] = 16'd2;
    set_exp(-18, -18, -18, -18, -18, -18, -18, -18);
    run_frame(1, 0, 0, 0);

    // ch0 all +1, ch1 +/- alternating; start shares the edge with the last weight bit.
    load_weights({9'h155, 9'h1FF}, 1);
    for (int i = 0; i < NPIX; i++) pix[i] = DW'(i);
    set_exp(45, 54, 81, 90, 5, 6, 9, 10);
    run_frame(0, 0, 0, 0);

    // Same weights retained; gaps, backpressure and ignored weight_en while busy.
    run_frame(1, 1, 1, 1);

    // Reset mid-frame, then a frame with the cleared (all -1) weights.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    io.dout_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      io.din_valid = 1'b1;
      io.din       = DW'(i + 7);
      @(negedge clk);
    end
    rstn = 1'b0;
    io.din_valid = 1'b0;
    #1;
    check_val("midrst_busy", busy, 0);
    check_val("midrst_din_ready", io.din_ready, 0);
    check_val("midrst_dout_valid", io.dout_valid, 0);
    check_val("midrst_dout", io.dout, 0);
    @(negedge clk);
    rstn = 1'b1;
    set_exp(-45, -54, -81, -90, -45, -54, -81, -90);
    run_frame(1, 0, 0, 0);

    load_weights({9'h155, 9'h1FF}, 0);
    set_exp(45, 54, 81, 90, 5, 6, 9, 10);
    run_frame(1, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
